// File: rtl/gcd_pkg.sv
// Shared types for the GCD request driver: core widths, FSM states and the
// request record that travels through the request FIFO.
package gcd_pkg;

  localparam int GCD_W    = 16;  // operand/result width of the GCD core
  localparam int GCD_TAGW = 4;   // request tag width, echoed on the response

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } gcd_drv_state_t;

  typedef struct packed {
    logic [GCD_TAGW-1:0] tag;
    logic [GCD_W-1:0]    x;
    logic [GCD_W-1:0]    y;
  } gcd_req_t;

  // Increment that sticks at all-ones, used for the timeout event counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/gcd_req_driver_fifo.sv
// Synchronous request FIFO holding gcd_req_t records. DEPTH must be a power
// of two so the read/write pointers wrap naturally. Push is ignored when
// full and pop is ignored when empty.
module gcd_req_fifo
  import gcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  gcd_req_t din,
  output gcd_req_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  gcd_req_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Next pointer/occupancy values from the qualified push and pop strobes.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents only matter once the occupancy says so.
  // NOTE: the storage array is deliberately not reset -- the pointers define
  // validity, and leaving it out of reset keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/gcd_req_driver.sv
// Initiator for the GCD core handshake. Requests are buffered in a FIFO,
// each pair is loaded into the core with start low for one cycle, run with
// start high until the core reports rdy (or a cycle budget expires), and the
// tagged result is offered downstream on a valid/ready port.
module gcd_req_driver
  import gcd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 70000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [GCD_W-1:0]    req_x,
  input  logic [GCD_W-1:0]    req_y,
  input  logic [GCD_TAGW-1:0] req_tag,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [GCD_W-1:0]    rsp_gcd,
  output logic [GCD_TAGW-1:0] rsp_tag,
  output logic                rsp_timeout,
  output logic [GCD_W-1:0]    core_xi,
  output logic [GCD_W-1:0]    core_yi,
  output logic                core_start,
  input  logic                core_rdy,
  input  logic [GCD_W-1:0]    core_xo,
  output logic [7:0]          timeout_cnt
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  RUN_LAST = CW'(TIMEOUT - 1);

  gcd_drv_state_t        state_q, state_d;
  logic [GCD_W-1:0]      core_xi_q, core_xi_d;
  logic [GCD_W-1:0]      core_yi_q, core_yi_d;
  logic                  core_start_q, core_start_d;
  logic [GCD_TAGW-1:0]   tag_q, tag_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [GCD_W-1:0]      rsp_gcd_q, rsp_gcd_d;
  logic [GCD_TAGW-1:0]   rsp_tag_q, rsp_tag_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0]         run_cnt_q, run_cnt_d;
  logic [7:0]            timeout_cnt_q, timeout_cnt_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  gcd_req_t              fifo_din, fifo_dout;

  // No pass-through: a full FIFO refuses even if it pops on the same edge.
  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && !fifo_full;
  assign fifo_din  = '{tag: req_tag, x: req_x, y: req_y};

  gcd_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state and datapath decisions for the load/run/respond sequence.
  // NOTE: every signal gets its hold value first so no path through the
  // case statement leaves one unassigned (which would infer a latch).
  always_comb begin
    state_d       = state_q;
    core_xi_d     = core_xi_q;
    core_yi_d     = core_yi_q;
    core_start_d  = core_start_q;
    tag_d         = tag_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_gcd_d     = rsp_gcd_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_timeout_d = rsp_timeout_q;
    run_cnt_d     = run_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    fifo_pop      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          core_xi_d    = fifo_dout.x;
          core_yi_d    = fifo_dout.y;
          tag_d        = fifo_dout.tag;
          core_start_d = 1'b0;
          state_d      = LOAD;
        end
      end

      LOAD: begin
        // Core samples operands this cycle with start low; run next cycle.
        run_cnt_d    = '0;
        core_start_d = 1'b1;
        state_d      = RUN;
      end

      RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        if (core_rdy) begin
          // A result arriving on the last budgeted cycle still counts.
          rsp_gcd_d     = core_xo;
          rsp_tag_d     = tag_q;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          core_start_d  = 1'b0;
          state_d       = RESP;
        end else if (run_cnt_q == RUN_LAST) begin
          rsp_gcd_d     = '0;
          rsp_tag_d     = tag_q;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          core_start_d  = 1'b0;
          timeout_cnt_d = sat_inc8(timeout_cnt_q);
          state_d       = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop     = 1'b1;
            core_xi_d    = fifo_dout.x;
            core_yi_d    = fifo_dout.y;
            tag_d        = fifo_dout.tag;
            core_start_d = 1'b0;
            state_d      = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, operand, response and counter registers; reset drops any
  // in-flight request without producing a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      core_xi_q     <= '0;
      core_yi_q     <= '0;
      core_start_q  <= 1'b0;
      tag_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_gcd_q     <= '0;
      rsp_tag_q     <= '0;
      rsp_timeout_q <= 1'b0;
      run_cnt_q     <= '0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      core_xi_q     <= core_xi_d;
      core_yi_q     <= core_yi_d;
      core_start_q  <= core_start_d;
      tag_q         <= tag_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_gcd_q     <= rsp_gcd_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_timeout_q <= rsp_timeout_d;
      run_cnt_q     <= run_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign core_xi     = core_xi_q;
  assign core_yi     = core_yi_q;
  assign core_start  = core_start_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_gcd     = rsp_gcd_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_timeout = rsp_timeout_q;
  assign timeout_cnt = timeout_cnt_q;

endmodule
